// File: rtl/result_accumulator.sv
// result_accumulator: sums a programmable number of adder results into one saturating frame sum.
module result_accumulator #(
    parameter int DATA_W = 40,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CNT_W-1:0]  len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
    state_t            state;
    logic [DATA_W-1:0] acc;
    logic              ovf;
    logic [CNT_W:0]    cnt, len_q, len_eff, cnt_nx;
    logic [DATA_W:0]   sum;
    logic              accept;
    assign in_ready  = state != OUT;
    assign out_valid = state == OUT;
    assign out_data  = out_valid ? acc : '0;
    assign out_ovf   = out_valid & ovf;
    assign accept    = in_valid & in_ready;
    // len of zero encodes the longest frame, which needs the extra counter bit
    assign len_eff   = len == '0 ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};
    assign sum       = {1'b0, acc} + {1'b0, in_data};
    assign cnt_nx    = cnt + (CNT_W+1)'(1);
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    acc   <= in_data;
                    cnt   <= (CNT_W+1)'(1);
                    ovf   <= 1'b0;
                    len_q <= len_eff;
                    state <= len_eff == (CNT_W+1)'(1) ? OUT : ACC;
                end
                ACC: if (accept) begin
                    acc   <= sum[DATA_W] ? '1 : sum[DATA_W-1:0];
                    ovf   <= ovf | sum[DATA_W];
                    cnt   <= cnt_nx;
                    state <= cnt_nx == len_q ? OUT : ACC;
                end
                OUT: if (out_ready) begin
                    state <= IDLE;
                    acc   <= '0;
                    cnt   <= '0;
                    ovf   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_accumulator.sv
// tb_result_accumulator: randomized and directed checks against a frame-level sum model.
module tb_result_accumulator;
    localparam logic [63:0] MAX = 64'hFF_FFFF_FFFF;
    logic        clk = 0, nrst = 0, clear = 0, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, out_ovf;
    logic [39:0] in_data = '0, out_data;
    logic [7:0]  len = '0;
    int          total = 0, bad = 0, nframes = 0;
    logic [39:0] last_out = '0;
    logic        last_ovf = 0;
    logic        m_have = 0, m_ovf = 0;
    logic [63:0] m_tot = 0, m_sum = 0;
    int          m_n = 0, m_len = 0;

    result_accumulator dut (
        .clk(clk), .nrst(nrst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .len(len), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // frame model: a frame is the plain total of its samples, clipped at the maximum
    always @(negedge nrst) begin
        m_have = 0; m_n = 0; m_tot = 0;
    end

    always @(negedge clk) if (nrst) begin
        chk("out_valid", 64'(out_valid), 64'(m_have));
        chk("in_ready", 64'(in_ready), 64'(!m_have));
        chk("out_data", 64'(out_data), m_have ? m_sum : 64'd0);
        chk("out_ovf", 64'(out_ovf), m_have ? 64'(m_ovf) : 64'd0);
        if (clear) begin
            m_have = 0; m_n = 0; m_tot = 0;
        end else if (m_have) begin
            if (out_ready) begin
                m_have = 0; nframes++;
                last_out = m_sum[39:0]; last_ovf = m_ovf;
            end
        end else if (in_valid) begin
            if (m_n == 0) m_len = (len == 0) ? 256 : int'(len);
            m_tot += 64'(in_data);
            m_n++;
            if (m_n == m_len) begin
                m_have = 1;
                m_sum  = (m_tot > MAX) ? MAX : m_tot;
                m_ovf  = m_tot > MAX;
                m_n = 0; m_tot = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [39:0] d, input logic [7:0] l);
        logic a;
        int k = 0;
        in_valid = 1; in_data = d; len = l;
        do begin
            @(negedge clk); a = in_ready;
            step();
            k++;
        end while (!a && k < 100);
        if (!a) chk("send_timeout", 64'(a), 64'd1);
    endtask

    task automatic idle();
        in_valid = 0;
    endtask

    task automatic wait_frame(input int target);
        for (int k = 0; k < 1000 && nframes < target; k++) @(posedge clk);
        #1;
        chk("frame_timeout", 64'(nframes >= target), 64'd1);
    endtask

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1 nrst = 1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        step();
        out_ready = 1;
        // four consecutive samples
        n0 = nframes;
        for (int i = 1; i <= 4; i++) send(40'(i), 8'd4);
        idle();
        wait_frame(n0 + 1);
        chk("len4_sum", 64'(last_out), 64'd10);
        chk("len4_ovf", 64'(last_ovf), 64'd0);
        // single-sample frame with a stalled consumer
        out_ready = 0; n0 = nframes;
        send(40'h00FFFFFFFF, 8'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; in_data = 40'h123; len = 8'd1;
            step();
        end
        idle();
        out_ready = 1;
        wait_frame(n0 + 1);
        chk("len1_sum", 64'(last_out), 64'h00FFFFFFFF);
        // full-length frame with random gaps
        n0 = nframes;
        for (int i = 0; i < 256; i++) begin
            send(40'hFFFFFFFF, 8'd0);
            if ($urandom % 3 == 0) begin idle(); step(); end
        end
        idle();
        wait_frame(n0 + 1);
        chk("len256_sum", 64'(last_out), 64'hFFFFFFFF00);
        chk("len256_ovf", 64'(last_ovf), 64'd0);
        // saturation, then a clean frame
        n0 = nframes;
        send(40'hFFFFFFFFFF, 8'd3); send(40'd1, 8'd3); send(40'd5, 8'd3);
        idle();
        wait_frame(n0 + 1);
        chk("sat_sum", 64'(last_out), 64'hFFFFFFFFFF);
        chk("sat_ovf", 64'(last_ovf), 64'd1);
        send(40'd2, 8'd2); send(40'd3, 8'd2);
        idle();
        wait_frame(n0 + 2);
        chk("post_sat_sum", 64'(last_out), 64'd5);
        chk("post_sat_ovf", 64'(last_ovf), 64'd0);
        // clear drops the partial frame and the sample presented with it
        n0 = nframes;
        send(40'd1, 8'd4); send(40'd2, 8'd4);
        in_valid = 1; in_data = 40'd3; clear = 1;
        step();
        clear = 0; idle();
        repeat (5) step();
        chk("clr_noframe", 64'(nframes), 64'(n0));
        send(40'd7, 8'd2); send(40'd8, 8'd2);
        idle();
        wait_frame(n0 + 1);
        chk("clr_next_sum", 64'(last_out), 64'd15);
        // len is latched on the first sample only
        n0 = nframes;
        send(40'd100, 8'd3); send(40'd20, 8'd1); send(40'd3, 8'd1);
        idle();
        wait_frame(n0 + 1);
        chk("len_latch_sum", 64'(last_out), 64'd123);
        chk("len_latch_cnt", 64'(nframes), 64'(n0 + 1));
        // asynchronous reset while holding a result
        out_ready = 0; n0 = nframes;
        send(40'd9, 8'd1);
        idle();
        @(posedge clk); #2;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        nrst = 0; #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_data", 64'(out_data), 64'd0);
        step();
        nrst = 1;
        @(negedge clk);
        chk("rst_rel_ready", 64'(in_ready), 64'd1);
        step();
        out_ready = 1;
        repeat (3) step();
        chk("rst_noframe", 64'(nframes), 64'(n0));
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = ($urandom % 8 == 0) ? {8'hFF, 32'($urandom)} : {8'h00, 32'($urandom)};
            len       = 8'($urandom_range(0, 8));
            out_ready = ($urandom % 3) != 0;
            clear     = ($urandom % 60) == 0;
            step();
        end
        in_valid = 0; clear = 0; out_ready = 1;
        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
